cpu_seq_ctrl: RTL and testbench
===============================

CPU_SEQ_CTRL -- requirements
Module: cpu_seq_ctrl

Interface
REQ-001: Parameter ADDR_W, default 5, instruction memory address width (32 bytes).
REQ-002: Parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-003: clk  input  1  single clock; all state changes on its rising edge.
REQ-004: rst_n  input  1  asynchronous, active-low reset.
REQ-005: load_start  input  1  one-cycle pulse; enter program-load mode and zero the load pointer.
REQ-006: load_done  input  1  one-cycle pulse; end program load early.
REQ-007: host_valid  input  1  host program byte valid.
REQ-008: host_data  input  8  host program byte.
REQ-009: host_ready  output  1  controller accepts host byte this cycle.
REQ-010: run  input  1  level; free-run the core while high.
REQ-011: step  input  1  one-cycle pulse; execute exactly one instruction.
REQ-012: clear  input  1  one-cycle pulse; leave HALTED and restart the core.
REQ-013: core_fetch_addr  input  ADDR_W  core fetch address (the core's PC low bits).
REQ-014: instr_done  input  1  core pulses high in its EXECUTE cycle.
REQ-015: core_halted  input  1  core is in its HALT state.
REQ-016: core_en  output  1  core may advance its FETCH/DECODE/EXECUTE state this cycle.
REQ-017: core_clr  output  1  one-cycle synchronous clear of core PC/AC/state.
REQ-018: mem_we / mem_addr / mem_wdata  output  1 / ADDR_W / 8  shared instruction memory port.
REQ-019: state  output  3  IDLE=0, LOAD=1, RUN=2, STEP=3, HALTED=4.
REQ-020: instr_count  output  CNT_W  retired instructions since last load_start or clear.

Function
REQ-021: States are IDLE, LOAD, RUN, STEP and HALTED; state is registered, and all other outputs except instr_count and load pointer are combinational from state and inputs.
REQ-022: IDLE: priority load_start > run > step; load_start -> LOAD, run=1 -> RUN, step -> STEP; else stay.
REQ-023: LOAD: host_ready=1; host_valid&host_ready -> mem_we=1, mem_addr=ptr, mem_wdata=host_data, ptr<=ptr+1.
REQ-024: LOAD exits to IDLE on the cycle the byte at ptr=2^ADDR_W-1 is written (ptr wraps to 0), or on load_done; simultaneous final write and load_done -> write performed, then IDLE.
REQ-025: load_start while in LOAD -> ptr<=0, stay LOAD; any accompanying host byte is written at the old ptr.
REQ-026: Entry into LOAD asserts core_clr for that cycle and zeroes instr_count.
REQ-027: Outside LOAD: host_ready=0, mem_we=0, mem_addr=core_fetch_addr; in LOAD, mem_addr=ptr and core_en=0.
REQ-028: RUN: core_en=1; run=0 -> IDLE next edge (core_en already 0 in the IDLE cycle); core_halted=1 -> HALTED with priority over run=0.
REQ-029: STEP: core_en=1 until instr_done; instr_done -> IDLE, or HALTED if core_halted is also 1.
REQ-030: HALTED: core_en=0; clear -> core_clr=1 that cycle, instr_count<=0, -> IDLE; run/step ignored.
REQ-031: instr_count increments by 1 on each instr_done with core_en=1, saturates at 2^CNT_W-1, never wraps.
REQ-032: step, run, clear in LOAD are ignored; load_start in RUN/STEP/HALTED is ignored.

Reset
REQ-033: rst_n low -> state=IDLE, ptr=0, instr_count=0, core_en=0, core_clr=0, mem_we=0, host_ready=0, immediately and independent of clk.
REQ-034: Reset mid-LOAD abandons the load; bytes already written remain in memory.

Verification
REQ-035: load_start, then 32 host bytes with host_valid held -> mem_we on 32 consecutive cycles, addresses 0..31, state returns to IDLE after byte 31.
REQ-036: load_start, 3 bytes (0x01,0x05,0x0A), load_done -> state=IDLE, ptr stops at 3, no further mem_we.
REQ-037: step pulse in IDLE, core signals instr_done 3 cycles later -> core_en high exactly 3 cycles, instr_count=1, state=IDLE.
REQ-038: run=1 with core reaching HALT after 4 instr_done -> state=HALTED, instr_count=4, core_en=0; clear -> core_clr pulse, instr_count=0, IDLE.
REQ-039: instr_count preset near max by 2^CNT_W+2 instr_done pulses in RUN -> holds at 0xFFFF.
REQ-040: rst_n asserted mid-RUN between clock edges -> core_en=0 and state=0 before next edge.

Source files
------------

// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: sequencing controller that sits between a host and a small core.
// It owns the shared instruction memory write port during program load and
// gates the core's FETCH/DECODE/EXECUTE progress for free-run and single-step.
// It also counts retired instructions, saturating at the counter maximum.
module cpu_seq_ctrl #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_done,
  input  logic              host_valid,
  input  logic [7:0]        host_data,
  output logic              host_ready,
  input  logic              run,
  input  logic              step,
  input  logic              clear,
  input  logic [ADDR_W-1:0] core_fetch_addr,
  input  logic              instr_done,
  input  logic              core_halted,
  output logic              core_en,
  output logic              core_clr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  instr_count
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_STEP   = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] PTR_LAST = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  state_t             state_reg, state_next;
  logic [ADDR_W-1:0]  ptr_reg, ptr_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic               in_load;
  logic               host_write;
  logic               count_zero;

  // Host port is only open while loading; a write happens on every valid byte.
  assign in_load    = (state_reg == ST_LOAD);
  assign host_write = in_load & host_valid;
  assign host_ready = in_load;
  assign mem_we     = host_write;
  assign mem_addr   = in_load ? ptr_reg : core_fetch_addr;
  assign state      = state_reg;
  assign instr_count = count_reg;

  // Write data is forced low outside LOAD so the shared memory bus stays quiet.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_wdata
      assign mem_wdata[gi] = host_data[gi] & in_load;
    end
  endgenerate

  // Next-state, load pointer and core handshake decode.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    core_en    = 1'b0;
    core_clr   = 1'b0;
    count_zero = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (load_start) begin
          // Entering LOAD restarts the core and the retired count.
          state_next = ST_LOAD;
          ptr_next   = '0;
          core_clr   = 1'b1;
          count_zero = 1'b1;
        end else if (run) begin
          state_next = ST_RUN;
        end else if (step) begin
          state_next = ST_STEP;
        end
      end
      ST_LOAD: begin
        if (host_write) begin
          ptr_next = ptr_reg + 1'b1;
        end
        if (load_start) begin
          // Restart: any byte in this cycle already went to the old pointer.
          ptr_next = '0;
        end else if (load_done || (host_write && (ptr_reg == PTR_LAST))) begin
          state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        core_en = 1'b1;
        if (core_halted) begin
          state_next = ST_HALTED;
        end else if (!run) begin
          state_next = ST_IDLE;
        end
      end
      ST_STEP: begin
        core_en = 1'b1;
        if (instr_done) begin
          state_next = core_halted ? ST_HALTED : ST_IDLE;
        end
      end
      ST_HALTED: begin
        if (clear) begin
          core_clr   = 1'b1;
          count_zero = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Retired-instruction counter: zeroed on load entry or clear, saturating otherwise.
  always_comb begin
    count_next = count_reg;
    if (count_zero) begin
      count_next = '0;
    end else if (instr_done && core_en && (count_reg != CNT_MAX)) begin
      count_next = count_reg + 1'b1;
    end
  end

  // State, pointer and counter registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      count_reg <= count_next;
    end
  end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed + randomized bench for cpu_seq_ctrl; expectations come from a
// scenario-level model (byte lists, instruction tallies, saturating sum).
module tb_cpu_seq_ctrl;

  localparam int ADDR_W = 5;
  localparam int CNT_W  = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              load_start, load_done, host_valid;
  logic [7:0]        host_data;
  logic              host_ready;
  logic              run, step, clear;
  logic [ADDR_W-1:0] core_fetch_addr;
  logic              instr_done, core_halted;
  logic              core_en, core_clr, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [2:0]        state;
  logic [CNT_W-1:0]  instr_count;

  int total = 0;
  int bad   = 0;
  int exp_cnt;

  cpu_seq_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .load_done(load_done),
    .host_valid(host_valid), .host_data(host_data), .host_ready(host_ready),
    .run(run), .step(step), .clear(clear),
    .core_fetch_addr(core_fetch_addr), .instr_done(instr_done),
    .core_halted(core_halted), .core_en(core_en), .core_clr(core_clr),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .state(state), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat_add(input int a, input int b);
    return (a + b > CNT_MAX) ? CNT_MAX : a + b;
  endfunction

  initial begin
    logic [7:0] bytes3 [3];
    logic [7:0] d8;
    logic [ADDR_W-1:0] fa;
    int gap, dly, n_instr, done_cnt, m;

    bytes3[0] = 8'h01; bytes3[1] = 8'h05; bytes3[2] = 8'h0A;
    rst_n = 1'b0; load_start = 0; load_done = 0; host_valid = 0; host_data = 0;
    run = 0; step = 0; clear = 0; core_fetch_addr = 0; instr_done = 0; core_halted = 0;
    exp_cnt = 0;

    // Reset values, observed with no clock edge yet.
    #2;
    chk("rst_state", state, 0);
    chk("rst_core_en", core_en, 0);
    chk("rst_core_clr", core_clr, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_host_ready", host_ready, 0);
    chk("rst_count", instr_count, 0);
    #10 rst_n = 1'b1;
    tick();

    // Full 32-byte load with host_valid held.
    load_start = 1; #1;
    chk("ld_entry_clr", core_clr, 1);
    chk("ld_entry_state", state, 0);
    tick(); load_start = 0;
    host_valid = 1;
    for (int i = 0; i < 32; i++) begin
      d8 = 8'($urandom);
      host_data = d8; #1;
      $display("txn load byte addr=%0d data=%02h", i, d8);
      chk("full_we", mem_we, 1);
      chk("full_addr", mem_addr, i);
      chk("full_data", mem_wdata, d8);
      chk("full_ready", host_ready, 1);
      chk("full_core_en", core_en, 0);
      chk("full_state", state, 1);
      tick();
    end
    host_data = 8'($urandom); #1;
    chk("full_exit_state", state, 0);
    chk("full_exit_we", mem_we, 0);
    chk("full_exit_ready", host_ready, 0);
    chk("full_count", instr_count, exp_cnt);
    host_valid = 0;
    fa = ADDR_W'($urandom); core_fetch_addr = fa; #1;
    chk("idle_mem_addr", mem_addr, fa);
    tick();

    // Short load with random gaps, then load_done.
    load_start = 1; tick(); load_start = 0;
    for (int k = 0; k < 3; k++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        host_valid = 0; #1;
        chk("gap_we", mem_we, 0);
        chk("gap_addr", mem_addr, k);
        chk("gap_state", state, 1);
        tick();
      end
      host_valid = 1; host_data = bytes3[k]; #1;
      $display("txn load byte addr=%0d data=%02h gap=%0d", k, bytes3[k], gap);
      chk("short_we", mem_we, 1);
      chk("short_addr", mem_addr, k);
      chk("short_data", mem_wdata, bytes3[k]);
      tick();
    end
    host_valid = 0; load_done = 1; #1;
    chk("done_state", state, 1);
    tick(); load_done = 0;
    host_valid = 1; host_data = 8'hEE; #1;
    chk("done_exit_state", state, 0);
    chk("done_no_we", mem_we, 0);
    tick(); host_valid = 0;

    // Restart mid-load and simultaneous final byte with load_done.
    load_start = 1; tick(); load_start = 0;
    host_valid = 1;
    for (int k = 0; k < 3; k++) begin host_data = 8'(k); tick(); end
    host_data = 8'h77; load_start = 1; #1;
    chk("restart_old_ptr", mem_addr, 3);
    chk("restart_we", mem_we, 1);
    tick(); load_start = 0;
    host_data = 8'h88; #1;
    chk("restart_new_ptr", mem_addr, 0);
    chk("restart_state", state, 1);
    tick();
    host_data = 8'h99; load_done = 1; #1;
    chk("simul_we", mem_we, 1);
    chk("simul_addr", mem_addr, 1);
    tick(); load_done = 0; #1;
    chk("simul_exit_state", state, 0);
    chk("simul_exit_we", mem_we, 0);
    host_valid = 0;
    tick();
    $display("txn restart/simultaneous load done");

    // Single step with instr_done after a random delay.
    dly = $urandom_range(1, 5);
    step = 1; #1;
    chk("step_idle_en", core_en, 0);
    tick(); step = 0;
    for (int k = 1; k <= dly; k++) begin
      instr_done = (k == dly); #1;
      chk("step_state", state, 3);
      chk("step_core_en", core_en, 1);
      tick();
    end
    instr_done = 0;
    exp_cnt = sat_add(exp_cnt, 1); #1;
    $display("txn step delay=%0d count=%0d", dly, exp_cnt);
    chk("step_exit_state", state, 0);
    chk("step_exit_en", core_en, 0);
    chk("step_count", instr_count, exp_cnt);
    tick();

    // Free run until the core halts after n instructions.
    n_instr = 4 + $urandom_range(0, 3);
    done_cnt = 0;
    run = 1; tick();
    while (done_cnt < n_instr) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        instr_done = 0; load_start = 1; #1;
        chk("run_state", state, 2);
        chk("run_core_en", core_en, 1);
        tick();
      end
      load_start = 0; instr_done = 1; #1;
      chk("run_core_en", core_en, 1);
      tick();
      done_cnt++;
      exp_cnt = sat_add(exp_cnt, 1);
    end
    instr_done = 0; core_halted = 1; #1;
    chk("run_halt_state", state, 2);
    tick(); #1;
    $display("txn run to halt instrs=%0d count=%0d", n_instr, exp_cnt);
    chk("halted_state", state, 4);
    chk("halted_core_en", core_en, 0);
    chk("halted_count", instr_count, exp_cnt);
    step = 1; load_start = 1; tick();
    step = 0; load_start = 0; run = 0; #1;
    chk("halted_ignore", state, 4);
    clear = 1; #1;
    chk("clear_core_clr", core_clr, 1);
    tick(); clear = 0; core_halted = 0;
    exp_cnt = 0; #1;
    chk("clear_state", state, 0);
    chk("clear_count", instr_count, exp_cnt);
    chk("clear_clr_low", core_clr, 0);
    tick();

    // Run, then drop run: one more enabled cycle, then IDLE.
    run = 1; tick();
    m = $urandom_range(3, 10);
    for (int k = 0; k < m; k++) begin
      instr_done = 1'($urandom); #1;
      if (instr_done) exp_cnt = sat_add(exp_cnt, 1);
      tick();
    end
    instr_done = 0; run = 0; #1;
    chk("stop_last_state", state, 2);
    chk("stop_last_en", core_en, 1);
    tick(); #1;
    $display("txn run/stop cycles=%0d count=%0d", m, exp_cnt);
    chk("stop_state", state, 0);
    chk("stop_core_en", core_en, 0);
    chk("stop_count", instr_count, exp_cnt);

    // Saturation: 2^CNT_W+2 retirements in RUN.
    run = 1; tick();
    instr_done = 1;
    repeat ((1 << CNT_W) + 2) tick();
    exp_cnt = sat_add(exp_cnt, (1 << CNT_W) + 2);
    instr_done = 0; #1;
    $display("txn saturate count=%0d", exp_cnt);
    chk("sat_count", instr_count, exp_cnt);
    chk("sat_state", state, 2);

    // Asynchronous reset between edges while running.
    @(posedge clk); #3;
    rst_n = 0; #1;
    chk("areset_state", state, 0);
    chk("areset_core_en", core_en, 0);
    chk("areset_count", instr_count, 0);
    @(negedge clk);
    run = 0; rst_n = 1;
    tick(); #1;
    $display("txn async reset mid-run");
    chk("post_reset_state", state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
